// File: rtl/branch_target_stage.sv
// Branch target stage: computes pc_plus4 + shift_in, resolves BEQ/BNE and
// sequences the PC redirect / flush of younger instructions.
//
// Ports:
//   Clk, Rst           - clock, asynchronous active-low reset
//   in_valid, stall    - input present / hold all state this cycle
//   shift_in, pc_plus4 - pre-shifted byte offset and PC+4 of the branch
//   branch_eq/ne, zero - branch kind and ALU zero flag
//   out_valid, target  - registered branch result (1-cycle latency)
//   pc_src, flush      - redirect pulse and squash window
//   taken_count        - taken branches since reset (wraps)
module branch_target_stage #(
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             in_valid,
    input  logic             stall,
    input  logic [31:0]      shift_in,
    input  logic [31:0]      pc_plus4,
    input  logic             branch_eq,
    input  logic             branch_ne,
    input  logic             zero,
    output logic             out_valid,
    output logic [31:0]      target,
    output logic             pc_src,
    output logic             flush,
    output logic [CNT_W-1:0] taken_count
);

    typedef enum logic {
        IDLE     = 1'b0,
        REDIRECT = 1'b1
    } state_t;

    localparam logic [2:0] LOAD = 3'(FLUSH_CYCLES);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [2:0]       r_cnt;
    logic [2:0]       w_cnt_nxt;
    logic             r_out_valid;
    logic [31:0]      r_target;
    logic             r_pc_src;
    logic             r_flush;
    logic [CNT_W-1:0] r_taken_count;

    logic             w_taken;
    logic             w_accept;
    logic             w_redirect;
    logic [31:0]      w_sum;

    // Both branch kinds at once is a malformed decode: never redirect on it.
    assign w_taken = ~(branch_eq & branch_ne)
                   & ((branch_eq & zero) | (branch_ne & ~zero));

    // Inputs arriving during REDIRECT are wrong-path and dropped.
    assign w_accept   = in_valid & ~stall & (r_state == IDLE);
    assign w_redirect = w_accept & w_taken;
    assign w_sum      = pc_plus4 + shift_in;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        if (!stall) begin
            unique case (r_state)
                IDLE: begin
                    if (w_redirect) begin
                        w_state_nxt = REDIRECT;
                        w_cnt_nxt   = LOAD;
                    end
                end
                REDIRECT: begin
                    if (r_cnt <= 3'd1) begin
                        w_cnt_nxt   = 3'd0;
                        w_state_nxt = IDLE;
                    end else begin
                        w_cnt_nxt   = r_cnt - 3'd1;
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = 3'd0;
                end
            endcase
        end
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            r_state       <= IDLE;
            r_cnt         <= 3'd0;
            r_out_valid   <= 1'b0;
            r_target      <= 32'd0;
            r_pc_src      <= 1'b0;
            r_flush       <= 1'b0;
            r_taken_count <= '0;
        end else if (!stall) begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_out_valid <= w_accept;
            if (w_accept) begin
                r_target <= w_sum;
            end
            // pc_src marks only the entry cycle; flush covers every
            // cycle spent in REDIRECT.
            r_pc_src <= w_redirect;
            r_flush  <= (w_state_nxt == REDIRECT);
            if (w_redirect) begin
                r_taken_count <= r_taken_count + CNT_W'(1);
            end
        end
    end

    assign out_valid   = r_out_valid;
    assign target      = r_target;
    assign pc_src      = r_pc_src;
    assign flush       = r_flush;
    assign taken_count = r_taken_count;

endmodule

// File: tb/tb_branch_target_stage.sv
// Scoreboard bench for branch_target_stage: directed branches push their
// expected result; an independent monitor pops on each new out_valid.
module tb_branch_target_stage;

    localparam int CNT_W = 2;

    logic             Clk;
    logic             Rst;
    logic             in_valid;
    logic             stall;
    logic [31:0]      shift_in;
    logic [31:0]      pc_plus4;
    logic             branch_eq;
    logic             branch_ne;
    logic             zero;
    logic             out_valid;
    logic [31:0]      target;
    logic             pc_src;
    logic             flush;
    logic [CNT_W-1:0] taken_count;

    typedef struct packed {
        logic [31:0] tgt;
        logic        pcs;
        logic        fl;
        logic [1:0]  cnt;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;
    logic last_stall = 1'b0;

    branch_target_stage #(
        .FLUSH_CYCLES(2),
        .CNT_W       (CNT_W)
    ) dut (
        .Clk        (Clk),
        .Rst        (Rst),
        .in_valid   (in_valid),
        .stall      (stall),
        .shift_in   (shift_in),
        .pc_plus4   (pc_plus4),
        .branch_eq  (branch_eq),
        .branch_ne  (branch_ne),
        .zero       (zero),
        .out_valid  (out_valid),
        .target     (target),
        .pc_src     (pc_src),
        .flush      (flush),
        .taken_count(taken_count)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] sh,
                         input logic [31:0] pc, input logic beq,
                         input logic bne, input logic z);
        in_valid  = v;
        shift_in  = sh;
        pc_plus4  = pc;
        branch_eq = beq;
        branch_ne = bne;
        zero      = z;
    endtask

    task automatic push(input logic [31:0] t, input logic p,
                        input logic f, input logic [1:0] c);
        exp_t e;
        e.tgt = t;
        e.pcs = p;
        e.fl  = f;
        e.cnt = c;
        sb.push_back(e);
    endtask

    task automatic step();
        @(negedge Clk);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_ov"}, 32'(out_valid), 32'd0);
        chk({tag, "_tgt"}, target, 32'd0);
        chk({tag, "_pcs"}, 32'(pc_src), 32'd0);
        chk({tag, "_fl"}, 32'(flush), 32'd0);
        chk({tag, "_cnt"}, 32'(taken_count), 32'd0);
    endtask

    always @(posedge Clk) last_stall <= stall;

    // A result counts as new only after an unstalled edge; stalled cycles
    // just hold the previous one.
    always @(negedge Clk) begin
        if (Rst && out_valid && !last_stall) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL sb_unexpected: got target %h want none",
                         target);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("sb_target", target, e.tgt);
                chk("sb_pc_src", 32'(pc_src), 32'(e.pcs));
                chk("sb_flush", 32'(flush), 32'(e.fl));
                chk("sb_count", 32'(taken_count), 32'(e.cnt));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int fl;
        Rst   = 1'b0;
        stall = 1'b0;
        drive(0, 32'd0, 32'd0, 0, 0, 0);
        repeat (2) step();
        chk_zero("rst");
        Rst = 1'b1;

        // taken BEQ, then wrong-path inputs during both REDIRECT cycles
        drive(1, 32'h10, 32'h1004, 1, 0, 1);
        push(32'h1014, 1, 1, 2'd1);
        step();
        drive(1, 32'h4, 32'h500, 1, 0, 1);
        step();
        chk("sq_flush2", 32'(flush), 32'd1);
        chk("sq_pcs2", 32'(pc_src), 32'd0);
        chk("sq_ov2", 32'(out_valid), 32'd0);
        step();
        chk("sq_flush_end", 32'(flush), 32'd0);
        chk("sq_ov_end", 32'(out_valid), 32'd0);
        chk("sq_cnt", 32'(taken_count), 32'd1);
        chk("sq_tgt", target, 32'h1014);

        // backward target wrapping past zero, BNE taken
        drive(1, 32'hFFFF_FFF8, 32'h4, 0, 1, 0);
        push(32'hFFFF_FFFC, 1, 1, 2'd2);
        step();
        drive(0, 32'd0, 32'd0, 0, 0, 0);
        repeat (2) step();

        // not-taken branches back to back
        drive(1, 32'h40, 32'h2000, 1, 0, 0);
        push(32'h2040, 0, 0, 2'd2);
        step();
        drive(1, 32'h8, 32'h3000, 0, 1, 1);
        push(32'h3008, 0, 0, 2'd2);
        step();
        drive(1, 32'h20, 32'h100, 1, 1, 1);
        push(32'h120, 0, 0, 2'd2);
        step();
        drive(0, 32'd0, 32'd0, 0, 0, 0);
        step();
        chk("nt_ov", 32'(out_valid), 32'd0);
        chk("nt_hold", target, 32'h120);
        chk("nt_cnt", 32'(taken_count), 32'd2);
        chk("nt_flush", 32'(flush), 32'd0);

        // stalled input in IDLE is ignored
        stall = 1'b1;
        drive(1, 32'd0, 32'h900, 1, 0, 1);
        step();
        chk("stidle_ov", 32'(out_valid), 32'd0);
        chk("stidle_cnt", 32'(taken_count), 32'd2);
        chk("stidle_tgt", target, 32'h120);
        stall = 1'b0;

        // stall for three cycles mid-REDIRECT
        drive(1, 32'h100, 32'h8000, 1, 0, 1);
        push(32'h8100, 1, 1, 2'd3);
        step();
        fl = 0;
        if (flush) fl++;
        drive(1, 32'h4, 32'h700, 0, 1, 0);
        stall = 1'b1;
        repeat (3) begin
            step();
            if (flush) fl++;
            chk("st_pcs_hold", 32'(pc_src), 32'd1);
            chk("st_ov_hold", 32'(out_valid), 32'd1);
        end
        stall = 1'b0;
        drive(0, 32'd0, 32'd0, 0, 0, 0);
        repeat (3) begin
            step();
            if (flush) fl++;
        end
        chk("st_flush_total", 32'(fl), 32'd5);
        chk("st_pcs_end", 32'(pc_src), 32'd0);
        chk("st_cnt", 32'(taken_count), 32'd3);

        // fourth taken branch wraps the 2-bit counter, then reset mid-flush
        drive(1, 32'h4, 32'h10, 1, 0, 1);
        push(32'h14, 1, 1, 2'd0);
        step();
        drive(0, 32'd0, 32'd0, 0, 0, 0);
        #2 Rst = 1'b0;
        #1 chk_zero("arst");
        step();
        chk_zero("arst_hold");

        // accepted on the first edge after release
        Rst = 1'b1;
        drive(1, 32'hC, 32'h40, 0, 1, 0);
        push(32'h4C, 1, 1, 2'd1);
        step();
        drive(0, 32'd0, 32'd0, 0, 0, 0);
        repeat (3) step();
        chk("end_flush", 32'(flush), 32'd0);
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
